// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART receiver.
package uart_pkg;

    // Widest character the receiver datapath is sized for.
    localparam int UART_MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    // 2-of-3 vote used to reject single-sample glitches at mid-bit.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Bit-period timer and mid-bit 3-sample majority vote.
// The counter free-runs 0..CLOCK_BAUD_RATIO-1 and is realigned by restart
// on start detection. Samples are taken at counts H-1 and H; the third is
// the live synchronized line at count H+1, where the vote is presented
// together with a one-cycle bit_done strobe.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLOCK_BAUD_RATIO = 400
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic rx_s,
    output logic bit_done,
    output logic bit_val
);

    localparam int CW = $clog2(CLOCK_BAUD_RATIO);
    localparam int H  = CLOCK_BAUD_RATIO / 2;

    logic [CW-1:0] cnt;
    logic          smp0;
    logic          smp1;

    // Bit counter with restart, plus capture of the first two mid-bit samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            smp0 <= 1'b0;
            smp1 <= 1'b0;
        end else begin
            if (restart || cnt == CW'(CLOCK_BAUD_RATIO - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == CW'(H - 1)) begin
                smp0 <= rx_s;
            end
            if (cnt == CW'(H)) begin
                smp1 <= rx_s;
            end
        end
    end

    assign bit_done = (cnt == CW'(H + 1));
    assign bit_val  = majority3(smp0, smp1, rx_s);

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: 5-9 data bits, 1-2 stop bits, optional parity,
// majority-voted sampling and a valid/ready character output.
// Optional parity checking is compiled in with the macro UART_RX_PARITY_EN.
//
// Output handshake: data/frame_err/parity_err are held stable while valid=1;
// a character transfers on any cycle with valid && ready. A frame that
// completes while the previous character is still unaccepted is dropped and
// signalled by a one-cycle overrun pulse.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLOCK_BAUD_RATIO = 400,
    parameter int DATA_BITS        = 8,
    parameter int STOP_BITS        = 1,
    parameter int PARITY_ODD       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int IDX_W = $clog2(UART_MAX_DATA_BITS);

    uart_rx_state_t       state;
    logic [2:0]           sync_q;
    logic                 rx_s;
    logic                 start_edge;
    logic                 bit_done;
    logic                 bit_val;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc;
    logic                 final_stop;
`ifdef UART_RX_PARITY_EN
    logic                 par_acc;
    logic                 perr_acc;
`endif

    // Three-flop synchronizer; reset to 0 so a low line at release is not a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], rx};
        end
    end

    assign rx_s       = sync_q[2];
    assign start_edge = (state == IDLE) && sync_q[2] && !sync_q[1];
    assign busy       = (state != IDLE);

    uart_bit_sampler #(
        .CLOCK_BAUD_RATIO(CLOCK_BAUD_RATIO)
    ) u_sampler (
        .clk     (clk),
        .rst     (rst),
        .restart (start_edge),
        .rx_s    (rx_s),
        .bit_done(bit_done),
        .bit_val (bit_val)
    );

    assign final_stop = (state == STOP) && bit_done &&
                        (bit_idx == IDX_W'(STOP_BITS - 1));

    // Frame sequencer: start validation, data shift, parity and stop checks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_idx  <= '0;
            shreg    <= '0;
            ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc  <= 1'b0;
            perr_acc <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        if (bit_val) begin
                            state <= IDLE;
                        end else begin
                            state    <= DATA;
                            bit_idx  <= '0;
                            ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            par_acc  <= 1'b0;
`endif
                        end
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                        par_acc <= par_acc ^ bit_val;
`endif
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        perr_acc <= par_acc ^ bit_val ^ (PARITY_ODD != 0);
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        ferr_acc <= ferr_acc | ~bit_val;
                        if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= bit_val ? IDLE : WAIT_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on frame completion unless the held character is unaccepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (final_stop) begin
                if (!valid || ready) begin
                    data      <= shreg;
                    valid     <= 1'b1;
                    frame_err <= ferr_acc | ~bit_val;
`ifdef UART_RX_PARITY_EN
                    parity_err <= perr_acc;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed at 16 clocks per bit, 8 data bits, 1 stop bit.
module tb_uart_rx_framed;

    localparam int   R  = 16;
    localparam int   DB = 8;
    localparam int   SB = 1;
    localparam logic PO = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int   PAR_EN = 1;
`else
    localparam int   PAR_EN = 0;
`endif
    localparam int   LAT = 3 + R * (DB + PAR_EN + SB) + R / 2 + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          ready = 1'b1;
    logic [DB-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          busy;

    uart_rx_framed #(
        .CLOCK_BAUD_RATIO(R),
        .DATA_BITS       (DB),
        .STOP_BITS       (SB),
        .PARITY_ODD      (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // output monitor, sampled on the falling edge
    int            rise_cnt = 0;
    int            hi_cnt = 0;
    int            ovr_cnt = 0;
    int            busy_rise = 0;
    int            last_rise = 0;
    logic [DB-1:0] rise_data = '0;
    logic          rise_ferr = 1'b0;
    logic          rise_perr = 1'b0;
    logic          valid_q = 1'b0;
    logic          busy_q = 1'b0;

    always @(negedge clk) begin
        valid_q <= valid;
        busy_q  <= busy;
        if (!rst) begin
            if (valid && !valid_q) begin
                rise_cnt  <= rise_cnt + 1;
                last_rise <= cyc;
                rise_data <= data;
                rise_ferr <= frame_err;
                rise_perr <= parity_err;
            end
            if (valid)            hi_cnt    <= hi_cnt + 1;
            if (overrun)          ovr_cnt   <= ovr_cnt + 1;
            if (busy && !busy_q)  busy_rise <= busy_rise + 1;
        end
    end

    // scoreboard counters
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    int start_cyc = 0;

    task automatic sync_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (R) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller must be at posedge+1; rx is left at the last stop-bit value.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_val, input logic par_flip);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (PAR_EN != 0) drive_bit((^d) ^ PO ^ par_flip);
        for (int i = 0; i < SB; i++) drive_bit(stop_val);
    endtask

    typedef struct {
        logic [DB-1:0] din;
        logic          stop_val;
        logic          par_flip;
        logic [DB-1:0] exp_data;
        logic          exp_ferr;
        logic          exp_perr;
    } vec_t;

    vec_t vecs[6];

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int r0, h0, o0, b0;
        logic perr_flip;
        perr_flip = (PAR_EN != 0);

        vecs[0] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, perr_flip};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_perr", parity_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        idle(2 * R);

        // table-driven frames, consumer always ready
        for (int v = 0; v < 6; v++) begin
            sync_edge();
            r0 = rise_cnt;
            h0 = hi_cnt;
            send_frame(vecs[v].din, vecs[v].stop_val, vecs[v].par_flip);
            idle(2 * R);
            check($sformatf("vec%0d_count", v), rise_cnt - r0, 1);
            check($sformatf("vec%0d_hicycles", v), hi_cnt - h0, 1);
            check($sformatf("vec%0d_latency", v), last_rise - start_cyc, LAT);
            check($sformatf("vec%0d_data", v), rise_data, vecs[v].exp_data);
            check($sformatf("vec%0d_ferr", v), rise_ferr, vecs[v].exp_ferr);
            check($sformatf("vec%0d_perr", v), rise_perr, vecs[v].exp_perr);
        end

        // break: bad stop bit, then line held low for three frame times
        sync_edge();
        r0 = rise_cnt;
        send_frame(8'hA5, 1'b0, 1'b0);
        repeat (3 * R * (1 + DB + PAR_EN + SB)) @(posedge clk);
        #1;
        check("brk_count", rise_cnt - r0, 1);
        check("brk_data", rise_data, 8'hA5);
        check("brk_ferr", rise_ferr, 1);
        check("brk_busy_low", busy, 1);
        idle(2 * R);
        check("brk_busy_released", busy, 0);
        check("brk_count_after", rise_cnt - r0, 1);

        // short glitch on idle line: false start
        sync_edge();
        r0 = rise_cnt;
        b0 = busy_rise;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(3 * R);
        check("glitch_busy_pulse", busy_rise - b0, 1);
        check("glitch_no_valid", rise_cnt - r0, 0);
        check("glitch_idle", busy, 0);

        // back-to-back frames with consumer stalled
        ready = 1'b0;
        sync_edge();
        r0 = rise_cnt;
        o0 = ovr_cnt;
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        idle(2 * R);
        check("ovr_count", rise_cnt - r0, 1);
        check("ovr_pulse", ovr_cnt - o0, 1);
        check("ovr_data_held", data, 8'h12);
        check("ovr_valid_held", valid, 1);
        ready = 1'b1;
        sync_edge();
        check("ovr_valid_drop", valid, 0);

        // reset in the middle of the data bits, then a clean frame
        sync_edge();
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", data, 0);
        rst = 1'b0;
        r0 = rise_cnt;
        idle(2 * R);
        check("midrst_no_output", rise_cnt - r0, 0);
        sync_edge();
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(2 * R);
        check("post_rst_count", rise_cnt - r0, 1);
        check("post_rst_data", rise_data, 8'h7E);
        check("post_rst_ferr", rise_ferr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised successor to the basic UART receiver. Adds a configurable frame format (5–9 data bits, 1–2 stop bits, optional parity) and 3-sample majority voting at mid-bit. Delivers characters over a valid/ready handshake with per-character framing and parity error flags and an overrun indication. Sits between the board `rx` pin and the byte-oriented consumer logic, on the single system clock.

## Interface
- `CLOCK_BAUD_RATIO`, 400: clock cycles per bit period; legal range ≥ 8.
- `DATA_BITS`, 8: data bits per frame; legal range 5–9; sent LSB first.
- `STOP_BITS`, 1: legal values 1 or 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored unless `UART_RX_PARITY_EN` is defined.
- `clk`  input  1: system clock, rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `rx`  input  1: asynchronous serial line; idles high.
- `data`  output  DATA_BITS: received character; stable while `valid`=1.
- `valid`  output  1: character available.
- `ready`  input  1: consumer accepts; transfer occurs on a cycle with `valid && ready`.
- `frame_err`  output  1: qualified by `valid`; at least one stop bit sampled 0.
- `parity_err`  output  1: qualified by `valid`; parity mismatch.
- `overrun`  output  1: one-cycle pulse when a completed frame is dropped.
- `busy`  output  1: high in every state other than IDLE.

## Operation
- Input synchronizer: 3-flop chain; all flops reset to 0, so a line held low at reset release never produces a start.
- Start detect: synchronized falling edge (flop 3 = 1, flop 2 = 0) in IDLE. Detection cycle D sets bit counter to 0.
- Bit counter: runs 0..CLOCK_BAUD_RATIO-1, then wraps; each wrap advances the bit index. With H = CLOCK_BAUD_RATIO/2, samples are taken at counts H-1, H and H+1. The bit value is the majority of the three and is decided at count H+1.
- States: IDLE → START → DATA → PARITY (only with the macro) → STOP → IDLE. A break path runs STOP → WAIT_IDLE → IDLE.
- START: if the voted value is 1, treat it as a false start and return to IDLE. No output.
- DATA: shift DATA_BITS voted bits into a shift register, LSB first.
- STOP: vote each of the STOP_BITS stop bits; any 0 sets frame_err. After the last stop-bit decision:
  - If the last stop bit voted 0: go to WAIT_IDLE and stay until synchronized rx = 1.
  - Otherwise: go to IDLE.
- Output register is loaded with data, frame_err and parity_err one cycle after the final stop decision:
  - If `valid`=0, or `valid && ready` on that same cycle: load and assert `valid`.
  - Otherwise: keep the old character, discard the new one, pulse `overrun`.
- `valid` clears on the cycle after `valid && ready`, unless a new load occurs on that cycle.
- Framing-errored characters are delivered; they are not dropped.

## Timing
- Reset values: data=0, valid=0, frame_err=0, parity_err=0, overrun=0, busy=0; state=IDLE; counters=0.
- Reset mid-frame aborts the frame immediately. Nothing is delivered.
- Pin-to-detect latency: D = 3 cycles after the `rx` pin falls.
- `valid` rises at D + CLOCK_BAUD_RATIO·(DATA_BITS+P+STOP_BITS) + H + 2, where P = 1 with parity and 0 without.
- Receiver rearms: IDLE is entered on the cycle after the final stop decision, so back-to-back frames are accepted.
- Glitch immunity: a low pulse shorter than 2 cycles spanning the start mid-sample yields a false start, not a frame.
- `busy` falls on the IDLE entry cycle.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state present.
  - Parity bit checked against `PARITY_ODD`; `parity_err` reflects the result.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; frame length is 1+DATA_BITS+STOP_BITS bits.
  - `parity_err` is tied to 0.

## Structure
- Package `uart_pkg`:
  - enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE).
  - function `majority3`.
  - constant `UART_MAX_DATA_BITS` = 9.
- Sub-module `uart_bit_sampler` holds the bit counter, the 3 sample flops and the vote. Outputs: `bit_done` pulse and `bit_val`. Input: `restart` (asserted at D). The FSM, shift register and output register stay in the top module.

## Test plan
- Ratio 16, 8N1, send 0x55 with ready=1 → valid for 1 cycle at the specified cycle, data=0x55, frame_err=0.
- With `UART_RX_PARITY_EN`, even parity:
  - Send 0xA5 with parity bit 0 → parity_err=0.
  - Same frame with parity bit 1 → parity_err=1, data=0xA5.
- Stop bit forced 0, then line held low for 3 frame times → exactly one valid with frame_err=1. No further valid until rx returns high.
- 4-cycle low glitch on an idle line → busy pulses, no valid, state back in IDLE.
- Two back-to-back frames 0x12 and 0x34 with ready=0 → data stays 0x12, one-cycle overrun pulse. After ready=1, valid drops.
- `rst` asserted mid-DATA, then frame 0x7E sent → no output from the aborted frame; 0x7E received correctly.
